// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard front end: decoder states,
// modifier/prefix scancodes and status register bit positions.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_F0     = 2'd1,
        ST_E0     = 2'd2,
        ST_E0F0   = 2'd3
    } dec_state_t;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;

    localparam int STAT_READY   = 7;
    localparam int STAT_FULL    = 6;
    localparam int STAT_OVERRUN = 5;
    localparam int STAT_PAR_ERR = 4;
    localparam int STAT_FRM_ERR = 3;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational scan-set-2 make code to ASCII translation (US layout).
module ps2_scan2ascii
  import ps2_pkg::*;
#(
  parameter bit LOWERCASE = 1'b0
) (
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  input  logic       ctrl,
  output logic [6:0] ascii,
  output logic       valid
);

  logic [7:0] up;
  logic [7:0] pl;
  logic [7:0] ps;
  logic [7:0] ch;

  // Letters are stored upper case; case and ctrl are applied afterwards.
  always_comb begin
    up = 8'h00;
    case (code)
      8'h1C: up = "A";  8'h32: up = "B";  8'h21: up = "C";  8'h23: up = "D";
      8'h24: up = "E";  8'h2B: up = "F";  8'h34: up = "G";  8'h33: up = "H";
      8'h43: up = "I";  8'h3B: up = "J";  8'h42: up = "K";  8'h4B: up = "L";
      8'h3A: up = "M";  8'h31: up = "N";  8'h44: up = "O";  8'h4D: up = "P";
      8'h15: up = "Q";  8'h2D: up = "R";  8'h1B: up = "S";  8'h2C: up = "T";
      8'h3C: up = "U";  8'h2A: up = "V";  8'h1D: up = "W";  8'h22: up = "X";
      8'h35: up = "Y";  8'h1A: up = "Z";
      default: up = 8'h00;
    endcase
  end

  always_comb begin
    pl = 8'h00;
    ps = 8'h00;
    case (code)
      8'h45: {pl, ps} = {"0", ")"};
      8'h16: {pl, ps} = {"1", "!"};
      8'h1E: {pl, ps} = {"2", "@"};
      8'h26: {pl, ps} = {"3", "#"};
      8'h25: {pl, ps} = {"4", "$"};
      8'h2E: {pl, ps} = {"5", "%"};
      8'h36: {pl, ps} = {"6", "^"};
      8'h3D: {pl, ps} = {"7", "&"};
      8'h3E: {pl, ps} = {"8", "*"};
      8'h46: {pl, ps} = {"9", "("};
      8'h0E: {pl, ps} = {8'h60, "~"};
      8'h4E: {pl, ps} = {"-", "_"};
      8'h55: {pl, ps} = {"=", "+"};
      8'h5D: {pl, ps} = {"\\", "|"};
      8'h54: {pl, ps} = {"[", "{"};
      8'h5B: {pl, ps} = {"]", "}"};
      8'h4C: {pl, ps} = {";", ":"};
      8'h52: {pl, ps} = {"'", "\""};
      8'h41: {pl, ps} = {",", "<"};
      8'h49: {pl, ps} = {".", ">"};
      8'h4A: {pl, ps} = {"/", "?"};
      8'h5A: {pl, ps} = {8'h0D, 8'h0D};
      8'h66: {pl, ps} = {8'h08, 8'h08};
      8'h29: {pl, ps} = {8'h20, 8'h20};
      8'h76: {pl, ps} = {8'h1B, 8'h1B};
      default: {pl, ps} = 16'h0000;
    endcase
  end

  always_comb begin
    ch    = 8'h00;
    valid = 1'b0;
    if (up != 8'h00) begin
      valid = 1'b1;
      if (ctrl)
        ch = up & 8'h1F;
      else if (LOWERCASE && !(shift ^ caps))
        ch = up | 8'h20;
      else
        ch = up;
    end else if (pl != 8'h00) begin
      valid = 1'b1;
      ch    = shift ? ps : pl;
    end
    ascii = ch[6:0];
  end

endmodule

// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: sync + clock filter, frame capture, scancode
// decoder with modifiers, ASCII FIFO and a chip-select read port.
module ps2_kbd_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int LOWERCASE      = 0
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       key_clk,
    input  logic       key_din,
    input  logic       cs,
    input  logic [1:0] address,
    output logic [7:0] dout
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int FLW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    logic kc_s1, kc_s2, kd_s1, kd_s2, filt, filt_d;
    logic [FLW-1:0] flt_cnt;
    logic [9:0] shreg;
    logic [3:0] bit_cnt;
    logic [TW-1:0] to_cnt;
    logic scan_valid, par_evt, frm_evt;
    logic [7:0] scan_code;
    dec_state_t state;
    logic lshift, rshift, ctrl_l, ctrl_r, caps;
    logic push_vld;
    logic [6:0] push_char;
    logic [6:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic cs_d, overrun, par_err, frm_err;
    logic [7:0] err_cnt;
    logic [6:0] tr_ascii;
    logic tr_valid;

    wire fall     = filt_d & ~filt;
    wire [10:0] frame = {kd_s2, shreg};
    wire shift    = lshift | rshift;
    wire ctrl     = ctrl_l | ctrl_r;
    wire is_full  = (count == CW'(FIFO_DEPTH));
    wire is_empty = (count == '0);

    // Read handshake: an access is the first clk25 cycle with cs high;
    // dout is loaded on that edge and held until the next access.
    wire access   = cs & ~cs_d;
    wire pop      = access && (address == 2'd0) && !is_empty;
    wire push_ok  = push_vld && (!is_full || pop);
    wire ovr_evt  = push_vld && is_full && !pop;
    wire stat_clr = access && (address == 2'd1);

    ps2_scan2ascii #(.LOWERCASE(LOWERCASE != 0)) u_xlat (
        .code  (scan_code),
        .shift (shift),
        .caps  (caps),
        .ctrl  (ctrl),
        .ascii (tr_ascii),
        .valid (tr_valid)
    );

    // Filtered clock starts high so reset release never looks like an edge.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            {kc_s1, kc_s2, kd_s1, kd_s2} <= 4'b1111;
            filt    <= 1'b1;
            filt_d  <= 1'b1;
            flt_cnt <= '0;
        end else begin
            {kc_s1, kc_s2} <= {key_clk, kc_s1};
            {kd_s1, kd_s2} <= {key_din, kd_s1};
            filt_d         <= filt;
            if (kc_s2 == filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLW'(FILTER_LEN - 1)) begin
                filt    <= kc_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            scan_valid <= 1'b0;
            scan_code  <= '0;
            par_evt    <= 1'b0;
            frm_evt    <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            par_evt    <= 1'b0;
            frm_evt    <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame[0] || !frame[10]) begin
                        frm_evt <= 1'b1;
                    end else if (!(^frame[9:1])) begin
                        par_evt <= 1'b1;
                    end else begin
                        scan_valid <= 1'b1;
                        scan_code  <= frame[8:1];
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    shreg   <= {kd_s2, shreg[9:1]};
                end
            end else if (bit_cnt != '0) begin
                if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                    frm_evt <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state     <= ST_NORMAL;
            {lshift, rshift, ctrl_l, ctrl_r, caps} <= '0;
            push_vld  <= 1'b0;
            push_char <= '0;
        end else begin
            push_vld <= 1'b0;
            if (scan_valid) begin
                case (state)
                    ST_NORMAL: begin
                        if (scan_code == SC_BREAK)      state <= ST_F0;
                        else if (scan_code == SC_EXT)   state <= ST_E0;
                        else if (scan_code == SC_LSHIFT) lshift <= 1'b1;
                        else if (scan_code == SC_RSHIFT) rshift <= 1'b1;
                        else if (scan_code == SC_CTRL)   ctrl_l <= 1'b1;
                        else if (scan_code == SC_CAPS)   caps   <= ~caps;
                        else if (tr_valid) begin
                            push_vld  <= 1'b1;
                            push_char <= tr_ascii;
                        end
                    end
                    ST_F0: begin
                        state <= ST_NORMAL;
                        if (scan_code == SC_LSHIFT)      lshift <= 1'b0;
                        else if (scan_code == SC_RSHIFT) rshift <= 1'b0;
                        else if (scan_code == SC_CTRL)   ctrl_l <= 1'b0;
                    end
                    ST_E0: begin
                        if (scan_code == SC_BREAK) begin
                            state <= ST_E0F0;
                        end else begin
                            state <= ST_NORMAL;
                            if (scan_code == SC_CTRL) ctrl_r <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_NORMAL;
                        if (scan_code == SC_CTRL) ctrl_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (push_ok) mem[wr_ptr] <= push_char;
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            cs_d    <= 1'b0;
            overrun <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            err_cnt <= '0;
            dout    <= '0;
        end else begin
            cs_d <= cs;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;
            overrun <= (overrun & ~stat_clr) | ovr_evt;
            par_err <= (par_err & ~stat_clr) | par_evt;
            frm_err <= (frm_err & ~stat_clr) | frm_evt;
            if ((par_evt || frm_evt) && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
            if (access) begin
                case (address)
                    2'd0: dout <= pop ? {1'b1, mem[rd_ptr]} : 8'h00;
                    2'd1: begin
                        dout <= 8'h00;
                        dout[STAT_READY]   <= !is_empty;
                        dout[STAT_FULL]    <= is_full;
                        dout[STAT_OVERRUN] <= overrun;
                        dout[STAT_PAR_ERR] <= par_err;
                        dout[STAT_FRM_ERR] <= frm_err;
                    end
                    2'd2: dout <= err_cnt;
                    default: dout <= {caps, ctrl, rshift, lshift, state, 2'b00};
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Directed bench for ps2_kbd_fifo: PS/2 frames are bit-banged and the CPU
// port is read back against hand-computed values.
module tb_ps2_kbd_fifo;

    localparam int DEPTH = 8;
    localparam int TMO   = 2000;

    logic       clk25 = 1'b0;
    logic       rst;
    logic       key_clk;
    logic       key_din;
    logic       cs;
    logic [1:0] address;
    logic [7:0] dout;
    logic [7:0] rd_val;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #20 clk25 = ~clk25;

    ps2_kbd_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO),
        .LOWERCASE      (0)
    ) dut (
        .clk25   (clk25),
        .rst     (rst),
        .key_clk (key_clk),
        .key_din (key_din),
        .cs      (cs),
        .address (address),
        .dout    (dout)
    );

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk25);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        key_din = b;
        wait_cyc(10);
        key_clk = 1'b0;
        wait_cyc(20);
        key_clk = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par);
        logic [10:0] f;
        f = {1'b1, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        key_din = 1'b1;
        wait_cyc(30);
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
        key_din = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input int hold, output logic [7:0] d);
        @(posedge clk25);
        #1;
        address = a;
        cs      = 1'b1;
        wait_cyc(hold);
        d  = dout;
        cs = 1'b0;
        wait_cyc(2);
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, 1, d);
        check(tag, d, exp);
    endtask

    initial begin
        rst = 1'b1; key_clk = 1'b1; key_din = 1'b1; cs = 1'b0; address = 2'd0;
        wait_cyc(5);
        check("reset_dout", dout, 8'h00);
        rst = 1'b0;
        wait_cyc(5);
        chk_rd("reset_status", 2'd1, 8'h00);
        chk_rd("reset_errcnt", 2'd2, 8'h00);
        chk_rd("reset_mods", 2'd3, 8'h00);

        // Plain make/break of 'A'
        send_frame(8'h1C, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h1C, 1'b0);
        chk_rd("a_data", 2'd0, 8'hC1);
        chk_rd("a_status", 2'd1, 8'h00);
        chk_rd("a_empty", 2'd0, 8'h00);

        // Shifted '2' gives '@', state field visible after a break prefix
        send_frame(8'h12, 1'b0);
        chk_rd("lshift_mods", 2'd3, 8'h10);
        send_frame(8'h1E, 1'b0); send_frame(8'hF0, 1'b0);
        chk_rd("f0_state_mods", 2'd3, 8'h14);
        send_frame(8'h1E, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h12, 1'b0);
        chk_rd("at_data", 2'd0, 8'hC0);
        chk_rd("shift_released", 2'd3, 8'h00);
        send_frame(8'h1E, 1'b0);
        chk_rd("two_data", 2'd0, 8'hB2);

        // Bad parity
        send_frame(8'h1C, 1'b1);
        chk_rd("par_no_push", 2'd0, 8'h00);
        chk_rd("par_status", 2'd1, 8'h10);
        chk_rd("par_errcnt", 2'd2, 8'h01);
        chk_rd("par_cleared", 2'd1, 8'h00);

        // Fill past capacity: A..I, nine makes
        send_frame(8'h1C, 1'b0); send_frame(8'h32, 1'b0); send_frame(8'h21, 1'b0);
        send_frame(8'h23, 1'b0); send_frame(8'h24, 1'b0); send_frame(8'h2B, 1'b0);
        send_frame(8'h34, 1'b0); send_frame(8'h33, 1'b0); send_frame(8'h43, 1'b0);
        chk_rd("full_status", 2'd1, 8'hE0);
        rd(2'd0, 4, rd_val);
        check("fifo_0_held_cs", rd_val, 8'hC1);
        for (int i = 1; i < DEPTH; i++) begin
            rd(2'd0, 1, rd_val);
            check($sformatf("fifo_%0d", i), rd_val, 8'hC1 + 8'(i));
        end
        chk_rd("drained_empty", 2'd0, 8'h00);
        chk_rd("drained_status", 2'd1, 8'h00);

        // Timeout mid-frame, then recovery with Enter
        send_bits(5);
        wait_cyc(TMO + 100);
        chk_rd("tmo_status", 2'd1, 8'h08);
        chk_rd("tmo_errcnt", 2'd2, 8'h02);
        send_frame(8'h5A, 1'b0);
        chk_rd("enter_data", 2'd0, 8'h8D);

        // Ctrl handling, left and right
        send_frame(8'h14, 1'b0);
        chk_rd("lctrl_mods", 2'd3, 8'h40);
        send_frame(8'h21, 1'b0);
        chk_rd("ctrl_c", 2'd0, 8'h83);
        send_frame(8'hF0, 1'b0); send_frame(8'h14, 1'b0);
        chk_rd("lctrl_released", 2'd3, 8'h00);
        send_frame(8'hE0, 1'b0); send_frame(8'h14, 1'b0);
        chk_rd("rctrl_mods", 2'd3, 8'h40);
        chk_rd("rctrl_no_push", 2'd0, 8'h00);
        send_frame(8'hE0, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h14, 1'b0);
        chk_rd("rctrl_released", 2'd3, 8'h00);

        // Caps lock toggles but letters stay upper case
        send_frame(8'h58, 1'b0);
        chk_rd("caps_on", 2'd3, 8'h80);
        send_frame(8'h1C, 1'b0);
        chk_rd("caps_a", 2'd0, 8'hC1);
        send_frame(8'h58, 1'b0);
        chk_rd("caps_off", 2'd3, 8'h00);

        // Reset in the middle of a frame, then one clean frame
        send_bits(4);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(5);
        send_frame(8'h1C, 1'b0);
        chk_rd("post_rst_data", 2'd0, 8'hC1);
        chk_rd("post_rst_empty", 2'd0, 8'h00);
        chk_rd("post_rst_status", 2'd1, 8'h00);
        chk_rd("post_rst_errcnt", 2'd2, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_fifo.md
PS2_KBD_FIFO -- requirements
Module: ps2_kbd_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, the ASCII FIFO entry count (power of 2, 2..64).
REQ-002 SHALL have parameter FILTER_LEN, default 8, the clk25 cycles key_clk must be stable before the filtered clock changes.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 25000, the maximum clk25 cycles between falling edges inside one frame (1 ms).
REQ-004 SHALL have parameter LOWERCASE, default 0: 0 = letters always upper case; 1 = case follows shift XOR caps.
REQ-005 SHALL have port clk25, input, 1 bit: 25 MHz clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have ports key_clk and key_din, input, 1 bit each: PS/2 clock and data from the device, asynchronous.
REQ-008 SHALL have port cs, input, 1 bit: CPU chip select, active high.
REQ-009 SHALL have port address, input, 2 bits: 0 = data, 1 = status, 2 = error count, 3 = modifiers.
REQ-010 SHALL have port dout, output, 8 bits: registered read data.

Function
REQ-011 SHALL double-flop key_clk and key_din, then filter the clock: the filtered level changes only after FILTER_LEN consecutive equal samples.
REQ-012 SHALL sample data on each filtered-clock falling edge into an 11-bit frame: start, 8 data bits LSB first, odd parity, stop.
REQ-013 SHALL accept a frame only when start=0, stop=1 and the parity is odd; it then produces one scancode-valid pulse.
REQ-014 SHALL discard a frame with bad parity and set sticky par_err; bad start or stop SHALL discard the frame and set sticky frm_err.
REQ-015 SHALL, when the bit count is nonzero and TIMEOUT_CYCLES pass with no falling edge, clear the bit count and set frm_err.
REQ-016 SHALL keep err_cnt, 8 bits: +1 per discarded frame or timeout, saturating at 255, cleared only by reset.
REQ-017 SHALL run a decoder FSM with states NORMAL, F0, E0 and E0F0:
- NORMAL: F0 goes to F0, E0 goes to E0, anything else is a make code.
- F0: break code, then back to NORMAL.
- E0: F0 goes to E0F0; anything else is an extended make, then NORMAL.
- E0F0: extended break, then NORMAL.
REQ-018 SHALL track modifiers: lshift (12), rshift (59), ctrl (14 and E0 14, OR of both), caps (58 make toggles); the matching break clears lshift, rshift and ctrl.
REQ-019 SHALL translate make codes through US layout (letters, digits, punctuation, shifted symbols, 5A=0x0D, 66=0x08, 29=0x20, 76=0x1B); modifier codes, unmapped codes and extended codes other than right ctrl SHALL push nothing.
REQ-020 SHALL map ctrl+letter to the letter code AND 0x1F.
REQ-021 SHALL push a translated character one cycle after the scancode-valid pulse; typematic repeats SHALL push again.
REQ-022 SHALL, when the FIFO is full and the same cycle has no pop, drop the character and set sticky overrun; a push and a pop in the same cycle on a full FIFO SHALL both succeed.
REQ-023 SHALL treat a read access as the first clk25 cycle of cs=1 (rising edge of cs); dout SHALL update on the next clock edge; a held cs SHALL cause one access only.
REQ-024 SHALL return {1, char[6:0]} and pop on an address-0 access to a non-empty FIFO; an empty FIFO SHALL return 0x00 with no pointer change.
REQ-025 SHALL return {ready, full, overrun, par_err, frm_err, 000} on an address-1 access, then clear the three sticky flags; an error event in the same cycle SHALL win.
REQ-026 SHALL return err_cnt on an address-2 access and {caps, ctrl, rshift, lshift, fsm_state[1:0], 00} on an address-3 access.
REQ-027 SHALL hold dout when no access occurs.

Reset
REQ-028 SHALL, on rst, clear the FIFO pointers and count, bit count, timeout counter, err_cnt, sticky flags, modifiers and dout, and set the FSM to NORMAL.
REQ-029 SHALL set the filtered clock to 1 on reset so no false edge follows; a frame in progress at reset SHALL be discarded.

Structure
REQ-030 SHALL place the FSM state encodings, the modifier scancodes and the status bit positions in shared package ps2_pkg.
REQ-031 SHALL implement translation in one combinational sub-module, ps2_scan2ascii, with inputs code, shift, caps, ctrl and LOWERCASE, and outputs ascii[6:0] and valid.

Verification
REQ-032 SHALL cover: frame 1C, then F0 1C -> one push; address-0 read gives 0xC1, then status ready=0.
REQ-033 SHALL cover: 12, 1E, F0 1E, F0 12 -> 0xC0 ('@'); then 1E -> 0xB2.
REQ-034 SHALL cover: frame 1C with even parity -> no push, status 0x10, err_cnt=1; a second status read gives 0x00.
REQ-035 SHALL cover: FIFO_DEPTH+1 makes with no reads -> full=1, overrun=1; FIFO_DEPTH reads return the first FIFO_DEPTH characters in order.
REQ-036 SHALL cover: 5 bits then silence of TIMEOUT_CYCLES+1 -> frm_err=1; the next valid frame 5A -> 0x8D.
REQ-037 SHALL cover: 14, 21 -> 0x83; also rst asserted mid-frame, then a clean frame -> exactly one correct push.
